sync_filter: RTL and testbench

//   Parametrised multi-channel input conditioner for asynchronous signals (UART rx line,

---
 rtl/sync_filter.sv | 66 ++++++
 tb/tb_sync_filter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: N-flop synchronizer, per-channel persistence filter,
// and registered rise/fall pulse generation.
module sync_filter #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_signal,
    output logic [WIDTH-1:0] output_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] sync;

    // Pure flop-to-flop chain: no logic between stages so every stage gets a full cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                chain[k] <= RESET_VAL;
            end
        end else begin
            chain[0] <= input_signal;
            for (int k = 1; k < STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
        end
    end

    assign sync = chain[STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;

        // NOTE: any cycle of agreement clears cnt, so separate short glitches never add up.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt              <= '0;
                output_signal[i] <= RESET_VAL[i];
                rise_pulse[i]    <= 1'b0;
                fall_pulse[i]    <= 1'b0;
            end else if (sync[i] == output_signal[i]) begin
                cnt           <= '0;
                rise_pulse[i] <= 1'b0;
                fall_pulse[i] <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                cnt              <= '0;
                output_signal[i] <= sync[i];
                rise_pulse[i]    <= sync[i];
                fall_pulse[i]    <= ~sync[i];
            end else begin
                cnt           <= cnt + CNT_W'(1);
                rise_pulse[i] <= 1'b0;
                fall_pulse[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: default configuration plus a wide, unfiltered, 3-stage instance.
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic       in_a;
    logic       out_a, rise_a, fall_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_filter dut_a (
        .clk           (clk),
        .reset         (reset_a),
        .input_signal  (in_a),
        .output_signal (out_a),
        .rise_pulse    (rise_a),
        .fall_pulse    (fall_a)
    );

    sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_LEN(1)) dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .input_signal  (in_b),
        .output_signal (out_b),
        .rise_pulse    (rise_b),
        .fall_pulse    (fall_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge then compare {output, rise, fall} of the default instance.
    task automatic expect_a(input string tag, input logic o, input logic r, input logic f);
        tick();
        check(tag, {29'd0, out_a, rise_a, fall_a}, {29'd0, o, r, f});
    endtask

    task automatic expect_b(input string tag, input logic [3:0] o, input logic [3:0] r,
                            input logic [3:0] f);
        tick();
        check(tag, {20'd0, out_b, rise_b, fall_b}, {20'd0, o, r, f});
    endtask

    initial begin
        int toggles_seen;

        reset_a = 1'b1;
        reset_b = 1'b1;
        in_a    = 1'b1;
        in_b    = 4'hF;
        #2;
        check("reset_a", {29'd0, out_a, rise_a, fall_a}, 32'b100);
        check("reset_b", {20'd0, out_b, rise_b, fall_b}, {20'd0, 4'hF, 4'h0, 4'h0});
        tick();
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;

        // 1: idle high, nothing happens
        for (int n = 0; n < 20; n++) expect_a("idle", 1'b1, 1'b0, 1'b0);

        // 2: held low -> falls at edge 6 with a single pulse
        in_a = 1'b0;
        for (int n = 1; n <= 8; n++) expect_a("fall_lat", n < 6, 1'b0, n == 6);

        // back to high: rises at edge 6
        in_a = 1'b1;
        for (int n = 1; n <= 8; n++) expect_a("rise_lat", n >= 6, n == 6, 1'b0);

        // 3: short glitches are rejected
        for (int len = 1; len <= 3; len++) begin
            in_a = 1'b0;
            for (int n = 1; n <= 12; n++) begin
                if (n == len + 1) in_a = 1'b1;
                expect_a($sformatf("glitch%0d", len), 1'b1, 1'b0, 1'b0);
            end
        end

        // 4-cycle low: falls at edge 6, then recovers at edge 10
        in_a = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 5) in_a = 1'b1;
            expect_a("glitch4", !(n >= 6 && n < 10), n == 10, n == 6);
        end

        // 5: reset mid-filter discards the partial count
        in_a = 1'b0;
        for (int n = 1; n <= 3; n++) expect_a("pre_rst", 1'b1, 1'b0, 1'b0);
        reset_a = 1'b1;
        #2;
        check("mid_rst", {29'd0, out_a, rise_a, fall_a}, 32'b100);
        tick();
        in_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int n = 1; n <= 4; n++) expect_a("post_rst", 1'b1, 1'b0, 1'b0);
        in_a = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 4) in_a = 1'b1;
            expect_a("post_rst_glitch", 1'b1, 1'b0, 1'b0);
        end

        // 6: toggling every cycle never gets through
        toggles_seen = 0;
        for (int n = 0; n < 100; n++) begin
            in_a = ~in_a;
            tick();
            if (out_a !== 1'b1 || rise_a !== 1'b0 || fall_a !== 1'b0) toggles_seen++;
        end
        check("toggle_hold", toggles_seen, 0);
        in_a = 1'b0;
        for (int n = 1; n <= 8; n++) expect_a("toggle_fall", n < 6, 1'b0, n == 6);

        // async reset from a low output returns to idle high, no pulses on release
        reset_a = 1'b1;
        #2;
        check("async_rst", {29'd0, out_a, rise_a, fall_a}, 32'b100);
        tick();
        reset_a = 1'b0;
        in_a    = 1'b1;
        for (int n = 1; n <= 4; n++) expect_a("rst_release", 1'b1, 1'b0, 1'b0);

        // 4: wide, 3 stages, no filter -> change at edge 4
        in_b = 4'h5;
        for (int n = 1; n <= 6; n++)
            expect_b("b_fall", (n >= 4) ? 4'h5 : 4'hF, 4'h0, (n == 4) ? 4'hA : 4'h0);
        in_b = 4'hF;
        for (int n = 1; n <= 6; n++)
            expect_b("b_rise", (n >= 4) ? 4'hF : 4'h5, (n == 4) ? 4'hA : 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
